// File: rtl/bnn_layer_engine.sv
// Time-multiplexed XNOR-popcount BNN layer: one neuron per clock, streamed weight loading.
// Optional per-neuron raw score output is enabled by defining BNN_SCORE_OUT_EN.
module bnn_layer_engine #(
    parameter  int N_IN   = 8,
    parameter  int N_OUT  = 4,
    parameter  int LOAD_W = 4,
    localparam int CW     = $clog2(N_IN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CW-1:0]         thr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN-1:0]       x_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_OUT-1:0]      out_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [LOAD_W-1:0]     load_data,
    input  logic                  load_restart,
    output logic                  busy,
    output logic [N_OUT*CW-1:0]   score_out
);

    localparam int NB = N_IN / LOAD_W;
    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t           state;
    logic [N_IN-1:0]  weights [N_OUT];
    logic [N_IN-1:0]  x_lat;
    logic [N_IN-1:0]  shadow;
    logic [N_IN-1:0]  record;
    logic [CW-1:0]    thr_lat;
    logic [CW-1:0]    match;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    ptr;
    logic [BW-1:0]    beat;
    logic             load_fire;
    logic             in_fire;
    logic             last_beat;

    function automatic logic [CW-1:0] popcount(input logic [N_IN-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N_IN; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Loads win over inferences in IDLE; a restart pulse blocks both for that cycle.
    assign load_ready = (state == IDLE) && !load_restart;
    assign in_ready   = (state == IDLE) && !load_valid && !load_restart;
    assign busy       = (state != IDLE);
    assign load_fire  = load_valid && load_ready;
    assign in_fire    = in_valid && in_ready;
    assign last_beat  = (beat == BW'(NB - 1));
    assign match      = popcount(~(x_lat ^ weights[idx]));

    // Shadow record with the incoming beat merged in, committed whole on the last beat.
    always_comb begin
        record = shadow;
        record[int'(beat)*LOAD_W +: LOAD_W] = load_data;
    end

    // Inference sequencer: latch input, evaluate one neuron per cycle, hold result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            x_lat     <= '0;
            thr_lat   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        x_lat   <= x_in;
                        thr_lat <= thr;
                        idx     <= '0;
                        state   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    out_data[idx] <= (match >= thr_lat);
                    if (idx == IW'(N_OUT - 1)) begin
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Weight loader: beats fill the shadow, the last beat commits to the pointed neuron.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < N_OUT; j++) begin
                weights[j] <= '0;
            end
            ptr    <= '0;
            beat   <= '0;
            shadow <= '0;
        end else if (load_restart) begin
            ptr    <= '0;
            beat   <= '0;
            shadow <= '0;
        end else if (load_fire) begin
            shadow <= record;
            if (last_beat) begin
                weights[ptr] <= record;
                beat         <= '0;
                ptr          <= (ptr == IW'(N_OUT - 1)) ? '0 : ptr + IW'(1);
            end else begin
                beat <= beat + BW'(1);
            end
        end
    end

`ifdef BNN_SCORE_OUT_EN
    logic [N_OUT*CW-1:0] score;

    // Raw match counts, written alongside the decision bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            score <= '0;
        end else if (state == COMPUTE) begin
            score[int'(idx)*CW +: CW] <= match;
        end
    end

    assign score_out = score;
`else
    assign score_out = '0;
`endif

endmodule

// File: tb/tb_bnn_layer_engine.sv
// Self-checking bench for bnn_layer_engine: directed scenarios plus randomized
// loads/inferences compared against a behavioural neuron model.
module tb_bnn_layer_engine;

    localparam int N_IN   = 8;
    localparam int N_OUT  = 4;
    localparam int LOAD_W = 4;
    localparam int CW     = 4;
    localparam int NB     = N_IN / LOAD_W;

    logic                clk = 1'b0;
    logic                reset;
    logic [CW-1:0]       thr;
    logic                in_valid;
    logic                in_ready;
    logic [N_IN-1:0]     x_in;
    logic                out_valid;
    logic                out_ready;
    logic [N_OUT-1:0]    out_data;
    logic                load_valid;
    logic                load_ready;
    logic [LOAD_W-1:0]   load_data;
    logic                load_restart;
    logic                busy;
    logic [N_OUT*CW-1:0] score_out;

    int checks = 0;
    int errors = 0;

    // Reference state: committed weights and the loader's view of the stream.
    logic [N_IN-1:0] w_m [N_OUT];
    logic [N_IN-1:0] sh_m;
    int              ptr_m;
    int              beat_m;

    bnn_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .LOAD_W(LOAD_W)) dut (
        .clk(clk), .reset(reset), .thr(thr),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_restart(load_restart), .busy(busy), .score_out(score_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j < N_OUT; j++) w_m[j] = '0;
        sh_m = '0; ptr_m = 0; beat_m = 0;
    endtask

    task automatic model_restart();
        sh_m = '0; ptr_m = 0; beat_m = 0;
    endtask

    task automatic model_beat(input logic [LOAD_W-1:0] d);
        sh_m[beat_m*LOAD_W +: LOAD_W] = d;
        if (beat_m == NB - 1) begin
            w_m[ptr_m] = sh_m;
            ptr_m = (ptr_m + 1) % N_OUT;
            beat_m = 0;
        end else begin
            beat_m++;
        end
    endtask

    // Neuron j fires when the number of agreeing bit positions reaches the threshold.
    task automatic model_eval(input logic [N_IN-1:0] x, input logic [CW-1:0] t,
                              output logic [N_OUT-1:0] o, output logic [N_OUT*CW-1:0] s);
        for (int j = 0; j < N_OUT; j++) begin
            int m = 0;
            for (int i = 0; i < N_IN; i++) if (x[i] == w_m[j][i]) m++;
            o[j] = (m >= int'(t));
            s[j*CW +: CW] = CW'(m);
        end
    endtask

    task automatic check_score(input string tag, input logic [N_OUT*CW-1:0] exp_s);
`ifdef BNN_SCORE_OUT_EN
        check(tag, score_out, exp_s);
`else
        check(tag, score_out, '0);
`endif
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    task automatic load_beat(input logic [LOAD_W-1:0] d);
        load_data = d; load_valid = 1'b1;
        #1 check("load_ready", load_ready, 1'b1);
        @(posedge clk); #1;
        load_valid = 1'b0;
        model_beat(d);
    endtask

    task automatic load_record(input logic [N_IN-1:0] r);
        for (int b = 0; b < NB; b++) load_beat(r[b*LOAD_W +: LOAD_W]);
    endtask

    task automatic restart_pulse();
        load_restart = 1'b1; load_valid = 1'b1; load_data = 4'hF;
        #1;
        check("restart_load_ready", load_ready, 1'b0);
        check("restart_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        load_restart = 1'b0; load_valid = 1'b0;
        model_restart();
    endtask

    task automatic infer(input logic [N_IN-1:0] x, input logic [CW-1:0] t,
                         input int hold, output logic [N_OUT-1:0] got);
        logic [N_OUT-1:0]    exp_o;
        logic [N_OUT*CW-1:0] exp_s;
        int                  waited;
        model_eval(x, t, exp_o, exp_s);
        x_in = x; thr = t; in_valid = 1'b1; waited = 0;
        #1;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1; waited++;
        end
        check("in_ready_wait", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; x_in = 8'($urandom); thr = 4'($urandom);
        check("busy_after_accept", busy, 1'b1);
        for (int k = 0; k < N_OUT; k++) begin
            check("out_valid_early", out_valid, 1'b0);
            @(posedge clk); #1;
        end
        check("out_valid_rise", out_valid, 1'b1);
        check("out_data", out_data, exp_o);
        check_score("score_out", exp_s);
        got = out_data;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; x_in = 8'($urandom);
            #1 check("hold_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_out_data", out_data, exp_o);
            check("hold_busy", busy, 1'b1);
            check_score("hold_score", exp_s);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 1'b0);
        check("post_busy", busy, 1'b0);
        check("post_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [N_OUT-1:0] got;
        logic [N_IN-1:0]  recs [5];
        reset = 1'b1; thr = '0; in_valid = 1'b0; x_in = '0; out_ready = 1'b0;
        load_valid = 1'b0; load_data = '0; load_restart = 1'b0;
        model_clear();
        do_reset(2);

        // Reset state
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_load_ready", load_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_score", score_out, '0);

        // Zero weights: all-zero input matches every bit, a single one breaks thr=8
        infer(8'h00, 4'd8, 0, got); check("t1_x00", got, 4'hF);
        infer(8'h01, 4'd8, 0, got); check("t1_x01", got, 4'h0);

        // Neuron0 = 0xAD, LSB nibble first
        load_beat(4'hD); load_beat(4'hA);
        infer(8'hAD, 4'd8, 0, got); check("t2_thr8", got, 4'h1);
        infer(8'hAD, 4'd4, 0, got); check("t2_thr4", got, 4'h1);
        // Back-pressure for 5 cycles with in_valid asserted
        infer(8'hAD, 4'd3, 5, got); check("t2_thr3", got, 4'hF);

        // Threshold extremes
        infer(8'($urandom), 4'd0, 0, got); check("thr_zero", got, 4'hF);
        infer(8'($urandom), 4'd9, 0, got); check("thr_over", got, 4'h0);

        // Reset two cycles into a computation
        x_in = 8'h00; thr = 4'd8; in_valid = 1'b1;
        #1 check("t4_in_ready", in_ready, 1'b1);
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        do_reset(1);
        check("t4_out_valid", out_valid, 1'b0);
        check("t4_busy", busy, 1'b0);
        check("t4_in_ready", in_ready, 1'b1);
        infer(8'h00, 4'd8, 0, got); check("t4_weights_zero", got, 4'hF);

        // Load and inference requested together: load wins
        load_data = 4'h6; load_valid = 1'b1; x_in = 8'h5A; thr = 4'd5; in_valid = 1'b1;
        #1;
        check("t5_in_ready_blocked", in_ready, 1'b0);
        check("t5_load_ready", load_ready, 1'b1);
        @(posedge clk); #1;
        model_beat(4'h6);
        check("t5_not_accepted", busy, 1'b0);
        load_valid = 1'b0;
        #1 check("t5_in_ready_back", in_ready, 1'b1);
        infer(8'h5A, 4'd5, 0, got);

        // Pointer wrap: five records, the fifth lands in neuron0
        restart_pulse();
        for (int r = 0; r < 5; r++) begin
            recs[r] = 8'($urandom);
            load_record(recs[r]);
        end
        infer(recs[4], 4'd8, 0, got); check("t6_wrap_n0", got[0], 1'b1);
        infer(recs[1], 4'd8, 0, got); check("t6_wrap_n1", got[1], 1'b1);

        // Partial record discarded by restart
        load_beat(4'h7);
        restart_pulse();
        load_record(8'h3C);
        infer(8'h3C, 4'd8, 0, got); check("t6_restart_n0", got[0], 1'b1);

        // Randomized loads and inferences
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: load_record(8'($urandom));
                1: load_beat(4'($urandom));
                2: restart_pulse();
                default: ;
            endcase
            infer(8'($urandom), 4'($urandom_range(0, 10)), int'($urandom_range(0, 2)), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
